// File: rtl/pulse_period_meter.sv
// Measures clk cycles between successive pulses on pulse_in and delivers each
// period through a valid/ready output register, with sticky timeout/overrun flags.
module pulse_period_meter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             pulse_in,
  input  logic [WIDTH-1:0] timeout,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             busy,
  output logic             overrun,
  output logic             timed_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] cnt;

  // busy decodes directly from the state flop, so it carries no extra logic depth
  assign busy = (state == MEASURE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      timed_out    <= 1'b0;
    end else if (clear) begin
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      timed_out    <= 1'b0;
      cnt          <= '0;
      state        <= enable ? ARMED : IDLE;
    end else begin
      // A transfer empties the output register; a new capture below may refill it.
      if (period_valid && period_ready) begin
        period_valid <= 1'b0;
      end

      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= ARMED;
          end
          ARMED: begin
            if (pulse_in) begin
              state <= MEASURE;
              cnt   <= CNT_ONE;
            end
          end
          MEASURE: begin
            if (pulse_in) begin
              cnt <= CNT_ONE;
              if (!period_valid || period_ready) begin
                period       <= cnt;
                period_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else if ((timeout != '0) && (cnt == timeout)) begin
              timed_out <= 1'b1;
              state     <= ARMED;
              cnt       <= '0;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
